// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage sitting between the PC block and the
// shared instruction/data memory port.
//
// Each fetch is a single outstanding read. The fetch address is captured from
// PCaddr when the fetch starts and is then held on mem_addr for the whole
// request. The returned word is latched into instr, and iready pulses for one
// cycle. A misaligned start address, or a read that stays busy for too long,
// sends the unit into a sticky fault state that only RST can clear.
//
// Ports:
//   clk          rising-edge clock
//   RST          synchronous, active-high reset
//   PCaddr       fetch address from the PC block
//   fetch_en     core run enable; a new fetch starts only while this is high
//   dmem_pending data side owns the memory port; blocks the start of a fetch
//   mem_busy     memory is still servicing the current read
//   mem_rdata    read data, valid when mem_busy is low during mem_read
//   mem_read     instruction read request
//   mem_addr     read address, stable for the whole request
//   instr        last fetched instruction
//   iready       one-cycle pulse: instr was updated, so the PC may advance
//   ifault       sticky fetch fault (misaligned address or timeout)

module fetch_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PCaddr,
  input  logic              fetch_en,
  input  logic              dmem_pending,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] instr,
  output logic              iready,
  output logic              ifault
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  // Encodings match the legacy localparam values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (RST) begin
      state  <= IDLE;
      addr_q <= '0;
      instr  <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en && !dmem_pending) begin
            if (PCaddr[1:0] != 2'b00) begin
              state <= FAULT;
            end else begin
              addr_q <= PCaddr;
              cnt    <= '0;
              state  <= REQ;
            end
          end
        end
        // A started fetch always runs to completion or timeout; fetch_en and
        // dmem_pending are deliberately not looked at here.
        REQ: begin
          if (!mem_busy) begin
            instr <= mem_rdata;
            state <= DONE;
          end else if (cnt == CNT_MAX) begin
            state <= FAULT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_read = (state == REQ);
    iready   = (state == DONE);
    ifault   = (state == FAULT);
    mem_addr = addr_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed and randomized checks of fetch_unit.
// Expected behaviour comes from a transaction-level view of a fetch:
// the number of stall cycles, the address and data of each transaction, and the
// last completed instruction word.

module tb_fetch_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          RST;
  logic [AW-1:0] PCaddr;
  logic          fetch_en;
  logic          dmem_pending;
  logic          mem_busy;
  logic [DW-1:0] mem_rdata;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] instr;
  logic          iready;
  logic          ifault;

  int unsigned checks;
  int unsigned failures;
  logic [DW-1:0] exp_instr;

  fetch_unit #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .RST(RST),
    .PCaddr(PCaddr),
    .fetch_en(fetch_en),
    .dmem_pending(dmem_pending),
    .mem_busy(mem_busy),
    .mem_rdata(mem_rdata),
    .mem_read(mem_read),
    .mem_addr(mem_addr),
    .instr(instr),
    .iready(iready),
    .ifault(ifault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // One complete fetch from IDLE. pend: cycles dmem_pending blocks the start;
  // waits: cycles mem_busy stays high. Expected: mem_read for waits+1 cycles at
  // address a, then one iready cycle with instr = data.
  task automatic do_fetch(input logic [AW-1:0] a, input logic set_pc,
                          input logic [DW-1:0] data, input int unsigned waits,
                          input int unsigned pend, input logic [AW-1:0] mid_pc);
    tick();
    chk("idle_rd", mem_read, 1'b0);
    chk("idle_rdy", iready, 1'b0);
    if (set_pc) PCaddr = a;
    fetch_en     = 1'b1;
    dmem_pending = (pend > 0);
    for (int unsigned p = 0; p < pend; p++) begin
      tick();
      chk("pend_rd", mem_read, 1'b0);
      if (p == pend - 1) dmem_pending = 1'b0;
    end
    for (int unsigned i = 0; i <= waits; i++) begin
      tick();
      chk("req_rd", mem_read, 1'b1);
      chk("req_addr", mem_addr, a);
      chk("req_rdy", iready, 1'b0);
      chk("req_instr", instr, exp_instr);
      mem_busy  = (i < waits);
      mem_rdata = (i < waits) ? $urandom : data;
      if (i == 0) begin
        PCaddr       = mid_pc;
        fetch_en     = 1'b0;
        dmem_pending = 1'b1;
      end else begin
        fetch_en     = 1'($urandom_range(1));
        dmem_pending = 1'($urandom_range(1));
      end
    end
    tick();
    exp_instr = data;
    chk("done_rdy", iready, 1'b1);
    chk("done_instr", instr, exp_instr);
    chk("done_rd", mem_read, 1'b0);
    chk("done_flt", ifault, 1'b0);
    fetch_en     = 1'b0;
    dmem_pending = 1'b0;
    mem_busy     = 1'b0;
  endtask

  initial begin
    int unsigned rd_cnt;
    int unsigned rdy_cnt;
    logic [AW-1:0] ra;
    checks    = 0;
    failures  = 0;
    exp_instr = '0;

    // Reset with fetch_en high and a zero-wait memory.
    RST          = 1'b1;
    PCaddr       = 32'h0000_0010;
    fetch_en     = 1'b1;
    dmem_pending = 1'b0;
    mem_busy     = 1'b0;
    mem_rdata    = 32'h0050_0093;
    tick();
    tick();
    chk("rst_rd", mem_read, 1'b0);
    chk("rst_rdy", iready, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flt", ifault, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    RST = 1'b0;

    // Zero-wait fetch: request one cycle after reset release, iready next.
    tick();
    chk("zw_rd", mem_read, 1'b1);
    chk("zw_addr", mem_addr, 32'h10);
    fetch_en = 1'b0;
    tick();
    exp_instr = 32'h0050_0093;
    chk("zw_rdy", iready, 1'b1);
    chk("zw_instr", instr, exp_instr);
    chk("zw_rd2", mem_read, 1'b0);
    tick();
    chk("zw_rdy_pulse", iready, 1'b0);

    // fetch_en low: stays idle.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en_low_rd", mem_read, 1'b0);
    end

    // Three wait states, PCaddr moved to 0x20 mid-request; the next fetch then
    // picks up 0x20 without the bench re-driving it.
    do_fetch(32'h10, 1'b1, 32'hDEAD_0013, 3, 0, 32'h20);
    do_fetch(32'h20, 1'b0, 32'h0000_0513, 0, 0, 32'h24);

    // Data side holds the port for 5 cycles.
    do_fetch(32'h30, 1'b1, 32'h1234_5678, 1, 5, 32'h34);

    // Misaligned address: sticky fault, no request.
    tick();
    PCaddr   = 32'h0000_0012;
    fetch_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mis_flt", ifault, 1'b1);
      chk("mis_rd", mem_read, 1'b0);
      chk("mis_rdy", iready, 1'b0);
    end
    RST      = 1'b1;
    fetch_en = 1'b0;
    tick();
    exp_instr = '0;
    chk("mis_clr_flt", ifault, 1'b0);
    chk("mis_clr_instr", instr, 32'h0);

    // Timeout: busy stuck high, request lasts TO+1 cycles, then fault.
    RST      = 1'b0;
    PCaddr   = 32'h40;
    fetch_en = 1'b1;
    mem_busy = 1'b1;
    rd_cnt   = 0;
    rdy_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_read) rd_cnt++;
      if (iready) rdy_cnt++;
    end
    chk("to_rd_cycles", 64'(rd_cnt), 64'(TO + 1));
    chk("to_rdy", 64'(rdy_cnt), 64'd0);
    chk("to_flt", ifault, 1'b1);
    chk("to_instr", instr, exp_instr);

    // Reset in the middle of a request.
    RST      = 1'b1;
    fetch_en = 1'b0;
    mem_busy = 1'b0;
    tick();
    RST = 1'b0;
    do_fetch(32'h44, 1'b1, 32'hCAFE_F00D, 0, 0, 32'h48);
    tick();
    PCaddr   = 32'h50;
    fetch_en = 1'b1;
    mem_busy = 1'b1;
    tick();
    chk("mr_rd0", mem_read, 1'b1);
    tick();
    chk("mr_rd1", mem_read, 1'b1);
    RST      = 1'b1;
    mem_busy = 1'b0;
    tick();
    exp_instr = '0;
    chk("mr_rd", mem_read, 1'b0);
    chk("mr_instr", instr, exp_instr);
    chk("mr_rdy", iready, 1'b0);
    RST      = 1'b0;
    fetch_en = 1'b0;

    // Randomized transactions (waits below the timeout).
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      ra[1:0] = 2'b00;
      do_fetch(ra, 1'b1, $urandom, $urandom_range(TO - 1), $urandom_range(2), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
